// File: rtl/press_pulse_pkg.sv
// Shared types and defaults for the push-button conditioning path.
package press_pulse_pkg;

  localparam int unsigned PP_STABLE_CYCLES_DEF = 4;
  localparam int unsigned PP_REPEAT_CYCLES_DEF = 16;

  localparam logic [1:0] S_LOW_ENC      = 2'b00;
  localparam logic [1:0] S_RISE_CHK_ENC = 2'b01;
  localparam logic [1:0] S_HIGH_ENC     = 2'b10;
  localparam logic [1:0] S_FALL_CHK_ENC = 2'b11;

  typedef enum logic [1:0] {
    S_LOW      = S_LOW_ENC,
    S_RISE_CHK = S_RISE_CHK_ENC,
    S_HIGH     = S_HIGH_ENC,
    S_FALL_CHK = S_FALL_CHK_ENC
  } pp_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; synchronous active-high reset to 0.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= 1'b0;
      q    <= 1'b0;
    end else begin
      s1_q <= d;
      q    <= s1_q;
    end
  end

endmodule

// File: rtl/press_pulse_gen.sv
// Synchronize, debounce and edge-detect a bouncy button into a one-cycle count-enable.
// Optional auto-repeat while held: define PRESS_PULSE_AUTO_REPEAT_EN.
module press_pulse_gen
  import press_pulse_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = PP_STABLE_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = PP_REPEAT_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_in,
  output logic       pulse_out,
  output logic       level_out,
  output logic [1:0] state_out
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES == 0 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("press_pulse_gen: STABLE_CYCLES must be >= 1 and REPEAT_CYCLES >= 2");
  end

  logic             s_q;
  pp_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d;
  logic             pulse_d;
  logic             rpt_fire;

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d     (btn_in),
    .q     (s_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_out;
    pulse_d = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (s_q) begin
          state_d = S_RISE_CHK;
          cnt_d   = '0;
        end
      end
      S_RISE_CHK: begin
        if (!s_q) begin
          state_d = S_LOW;
        end else if (cnt_q == CntMax) begin
          state_d = S_HIGH;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!s_q) begin
          state_d = S_FALL_CHK;
          cnt_d   = '0;
        end
      end
      S_FALL_CHK: begin
        if (s_q) begin
          state_d = S_HIGH;
        end else if (cnt_q == CntMax) begin
          state_d = S_LOW;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_LOW;
    endcase
  end

`ifdef PRESS_PULSE_AUTO_REPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RptMax = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;

  // Period holds through S_FALL_CHK so release bounce does not restart it.
  always_comb begin
    rpt_d    = rpt_q;
    rpt_fire = 1'b0;
    unique case (state_q)
      S_LOW, S_RISE_CHK: rpt_d = '0;
      S_HIGH: begin
        if (rpt_q == RptMax) begin
          rpt_fire = 1'b1;
          rpt_d    = '0;
        end else begin
          rpt_d = rpt_q + RPT_W'(1);
        end
      end
      default: rpt_d = rpt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_LOW;
      cnt_q     <= '0;
      level_out <= 1'b0;
      pulse_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_out <= level_d;
      pulse_out <= pulse_d | rpt_fire;
    end
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_press_pulse_gen.sv
// Randomized and directed bench for press_pulse_gen against a run-length debounce model.
module tb_press_pulse_gen;

  localparam int unsigned Stable = 4;
  localparam int unsigned Repeat = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_in = 1'b0;
  logic       pulse_out;
  logic       level_out;
  logic [1:0] state_out;

  press_pulse_gen #(
    .STABLE_CYCLES (Stable),
    .REPEAT_CYCLES (Repeat)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .btn_in    (btn_in),
    .pulse_out (pulse_out),
    .level_out (level_out),
    .state_out (state_out)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Model: the debounced level flips once Stable+1 consecutive synchronized samples disagree.
  bit m_s1, m_sq, m_level, m_pulse;
  int m_run, m_rpt;

  logic [2:0] ctr = 3'd0;
  int edge_no, first_pulse, dut_pulses;
  bit saw_fall_chk;
  int pulse_edges[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
  endtask

  function automatic logic [1:0] model_state();
    if (!m_level) return (m_run == 0) ? 2'b00 : 2'b01;
    else          return (m_run == 0) ? 2'b10 : 2'b11;
  endfunction

  task automatic model_step(input logic r, input logic b);
    bit sample;
    if (r) begin
      m_s1 = 0; m_sq = 0; m_level = 0; m_run = 0; m_rpt = 0; m_pulse = 0;
    end else begin
      sample  = m_sq;
      m_pulse = 0;
`ifdef PRESS_PULSE_AUTO_REPEAT_EN
      if (!m_level) m_rpt = 0;
      else if (m_run == 0) begin
        if (m_rpt == Repeat - 1) begin m_pulse = 1; m_rpt = 0; end
        else m_rpt++;
      end
`endif
      if (sample != m_level) begin
        m_run++;
        if (m_run == Stable + 1) begin
          m_level = sample;
          m_run   = 0;
          if (m_level) begin m_pulse = 1; m_rpt = 0; end
        end
      end else begin
        m_run = 0;
      end
      m_sq = m_s1;
      m_s1 = b;
    end
  endtask

  task automatic step(input logic r, input logic b);
    reset  = r;
    btn_in = b;
    @(posedge clock);
    model_step(r, b);
    #1;
    edge_no++;
    if (pulse_out === 1'b1) begin
      ctr++;
      dut_pulses++;
      pulse_edges.push_back(edge_no);
      if (first_pulse < 0) first_pulse = edge_no;
    end
    if (state_out === 2'b11) saw_fall_chk = 1;
    check("pulse", {31'd0, pulse_out}, {31'd0, m_pulse});
    check("level", {31'd0, level_out}, {31'd0, m_level});
    check("state", {30'd0, state_out}, {30'd0, model_state()});
  endtask

  task automatic mark();
    edge_no = 0; first_pulse = -1; dut_pulses = 0; saw_fall_chk = 0;
    pulse_edges.delete();
  endtask

  initial begin
    int len;
    bit lvl;
    // Reset with the button already high
    repeat (2) step(1'b1, 1'b1);

    // Clean press
    mark();
    repeat (30) step(1'b0, 1'b1);
    check("press_latency", first_pulse, 7);
    check("press_pulses", dut_pulses, 1);
    repeat (10) step(1'b0, 1'b0);
    check("release_level", {31'd0, level_out}, 0);

    // Eight presses wrap the downstream 3-bit counter
    mark();
    ctr = 3'd0;
    repeat (8) begin
      repeat (10) step(1'b0, 1'b1);
      repeat (10) step(1'b0, 1'b0);
    end
    check("eight_pulses", dut_pulses, 8);
    check("counter_wrap", {29'd0, ctr}, 0);

    // Glitch shorter than the qualify window
    mark();
    repeat (3) step(1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0);
    check("glitch_pulses", dut_pulses, 0);
    check("glitch_state", {30'd0, state_out}, 0);

    // Release bounce absorbed
    repeat (12) step(1'b0, 1'b1);
    mark();
    repeat (2) step(1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1);
    check("bounce_fall_chk", {31'd0, saw_fall_chk}, 1);
    check("bounce_level", {31'd0, level_out}, 1);
    check("bounce_state", {30'd0, state_out}, 2);
    check("bounce_pulses", dut_pulses, 0);
    repeat (10) step(1'b0, 1'b0);

    // Reset during qualification
    mark();
    repeat (4) step(1'b0, 1'b1);
    check("mid_state", {30'd0, state_out}, 1);
    check("mid_pulses", dut_pulses, 0);
    step(1'b1, 1'b1);
    mark();
    repeat (12) step(1'b0, 1'b1);
    check("reset_latency", first_pulse, 7);
    check("reset_pulses", dut_pulses, 1);
    repeat (10) step(1'b0, 1'b0);

`ifdef PRESS_PULSE_AUTO_REPEAT_EN
    mark();
    repeat (60) step(1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b0);
    check("repeat_count", pulse_edges.size(), 4);
    for (int i = 0; i < 4 && i < pulse_edges.size(); i++)
      check("repeat_edge", pulse_edges[i], 7 + 16 * i);
`endif

    // Random bouncy stimulus with occasional resets
    lvl = 0;
    for (int i = 0; i < 300; i++) begin
      lvl = ~lvl;
      len = (($urandom % 4) == 0) ? $urandom_range(8, 40) : $urandom_range(1, 7);
      for (int j = 0; j < len; j++)
        step(($urandom % 64) == 0, lvl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
